// File: rtl/seven_seg_ctrl.sv
// seven_seg_ctrl: N-digit multiplexed 7-segment controller.
//   clk, rst                    system clock, synchronous active-high reset
//   i_valid/o_ready             load handshake; a load is accepted only in IDLE
//   i_data, i_hex, i_blank_lz   value plus display mode, sampled together on accept
//   o_overflow                  the last committed value did not fit in N_DIGITS
//   seg {g,f,e,d,c,b,a}, an     registered segment and anode drives (an[0] = rightmost)
module seven_seg_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_hex,
  input  logic                i_blank_lz,
  output logic                o_ready,
  output logic                o_overflow,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] DEC_LIM = pow10(N_DIGITS);
  localparam logic [63:0] HEX_LIM = 64'd1 << BCD_W;

  // Segment patterns in active-low form; inverted at the output for active-high boards.
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] r;
    r = SEG_BLANK;
    case (nib)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                blz_pend_q, blz_pend_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic                disp_blz_q, disp_blz_d;
  logic                ovf_q, ovf_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [63:0]         data_ext;
  logic [BCD_W-1:0]    hex_val;
  logic [BCD_W-1:0]    bcd_adj;

  assign data_ext = 64'(i_data);

  // Hex digits come straight from the input, truncated or zero-padded to the display width.
  if (DATA_W >= BCD_W) begin : g_hex_trunc
    assign hex_val = i_data[BCD_W-1:0];
  end else begin : g_hex_pad
    assign hex_val = {{(BCD_W - DATA_W){1'b0}}, i_data};
  end

  // Load / conversion / commit sequencing.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    blz_pend_d = blz_pend_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    disp_blz_d = disp_blz_q;
    ovf_d      = ovf_q;

    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          blz_pend_d = i_blank_lz;
          if (i_hex) begin
            ovf_pend_d = (data_ext >= HEX_LIM);
            bcd_d      = hex_val;
            state_d    = S_COMMIT;
          end else begin
            ovf_pend_d = (data_ext >= DEC_LIM);
            sh_d       = i_data;
            bcd_d      = '0;
            cnt_d      = CNT_W'(DATA_W);
            state_d    = S_CONV;
          end
        end
      end
      S_CONV: begin
        // The BCD MSB shifts out and is dropped; such values are already flagged as overflow.
        bcd_d = (bcd_adj << 1) | BCD_W'(sh_q[DATA_W-1]);
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d     = bcd_q;
        disp_blz_d = blz_pend_q;
        ovf_d      = ovf_pend_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit refresh timing.
  always_comb begin
    ref_d = ref_q + 1'b1;
    sel_d = sel_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      sel_d = (sel_q == SEL_W'(N_DIGITS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  // Output stage: decode the selected digit from the committed display registers.
  logic [3:0] nib;
  logic       lz_blank;
  logic [6:0] pat;
  logic [N_DIGITS-1:0] onehot;

  always_comb begin
    nib      = '0;
    lz_blank = 1'b0;
    onehot   = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      onehot[i] = (sel_q == SEL_W'(i));
      if (sel_q == SEL_W'(i)) begin
        nib      = disp_q[4*i +: 4];
        lz_blank = (i != 0);
        for (int unsigned j = i; j < N_DIGITS; j++) begin
          if (disp_q[4*j +: 4] != 4'd0) lz_blank = 1'b0;
        end
      end
    end

    if (ovf_q) begin
      pat = SEG_DASH;
    end else if (disp_blz_q && lz_blank) begin
      pat = SEG_BLANK;
    end else begin
      pat = decode(nib);
    end

    seg_d = ACTIVE_LOW ? pat : ~pat;
    an_d  = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      blz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      disp_blz_q <= 1'b0;
      ovf_q      <= 1'b0;
      ref_q      <= '0;
      sel_q      <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      blz_pend_q <= blz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      disp_blz_q <= disp_blz_d;
      ovf_q      <= ovf_d;
      ref_q      <= ref_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_overflow = ovf_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seven_seg_ctrl.sv
module tb_seven_seg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // A: N=4, DATA_W=14, REFRESH_DIV=4, active-low
  logic va, hxa, bza, rdya, ofa;
  logic [13:0] da;
  logic [6:0]  sa;
  logic [3:0]  ana;
  // B: N=4, DATA_W=16, REFRESH_DIV=4, active-low
  logic vb, hxb, bzb, rdyb, ofb;
  logic [15:0] db;
  logic [6:0]  sb;
  logic [3:0]  anb;
  // C: N=3, DATA_W=10, REFRESH_DIV=5, active-high
  logic vc, hxc, bzc, rdyc, ofc;
  logic [9:0]  dc;
  logic [6:0]  sc;
  logic [2:0]  anc;

  seven_seg_ctrl #(.N_DIGITS(4), .DATA_W(14), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .i_valid(va), .i_data(da), .i_hex(hxa), .i_blank_lz(bza),
    .o_ready(rdya), .o_overflow(ofa), .seg(sa), .an(ana));
  seven_seg_ctrl #(.N_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .i_valid(vb), .i_data(db), .i_hex(hxb), .i_blank_lz(bzb),
    .o_ready(rdyb), .o_overflow(ofb), .seg(sb), .an(anb));
  seven_seg_ctrl #(.N_DIGITS(3), .DATA_W(10), .REFRESH_DIV(5), .ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst(rst), .i_valid(vc), .i_data(dc), .i_hex(hxc), .i_blank_lz(bzc),
    .o_ready(rdyc), .o_overflow(ofc), .seg(sc), .an(anc));

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected active-low pattern of digit k for value v on an n-digit display.
  function automatic logic [6:0] model_seg(input int unsigned v, input bit hx, input bit blz,
                                           input int unsigned n, input int unsigned k);
    longint unsigned base = hx ? 16 : 10;
    longint unsigned pk = 1;
    longint unsigned lim;
    for (int unsigned i = 0; i < k; i++) pk *= base;
    lim = pk;
    for (int unsigned i = k; i < n; i++) lim *= base;
    if (v >= lim) return 7'h3F;
    if (blz && k != 0 && v < pk) return 7'h7F;
    return seg_tab[int'((v / pk) % base)];
  endfunction

  function automatic bit model_ovf(input int unsigned v, input bit hx, input int unsigned n);
    longint unsigned lim = 1;
    for (int unsigned i = 0; i < n; i++) lim *= (hx ? 16 : 10);
    return v >= lim;
  endfunction

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return rdya;
      1:       return rdyb;
      default: return rdyc;
    endcase
  endfunction

  // Present one load while the selected DUT is idle; lows = cycles o_ready stayed low.
  task automatic load(input int d, input int unsigned v, input bit hx, input bit blz,
                      output int lows);
    case (d)
      0:       begin va = 1'b1; da = 14'(v); hxa = hx; bza = blz; end
      1:       begin vb = 1'b1; db = 16'(v); hxb = hx; bzb = blz; end
      default: begin vc = 1'b1; dc = 10'(v); hxc = hx; bzc = blz; end
    endcase
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    lows = 0;
    while (rdy_of(d) !== 1'b1 && lows < 200) begin
      lows++;
      @(posedge clk); #1;
    end
  endtask

  // Record one full refresh round; seg stored active-low, seen marks digits observed.
  task automatic capture(input int d, output logic [55:0] segs, output logic [7:0] seen);
    int unsigned n = (d == 2) ? 3 : 4;
    int unsigned rd = (d == 2) ? 5 : 4;
    logic [7:0] a;
    logic [6:0] s;
    segs = '0;
    seen = '0;
    repeat (n * rd + 1) begin
      @(posedge clk); #1;
      case (d)
        0:       begin a = {4'h0, ~ana}; s = sa; end
        1:       begin a = {4'h0, ~anb}; s = sb; end
        default: begin a = {5'h0, anc}; s = ~sc; end
      endcase
      for (int unsigned i = 0; i < n; i++) begin
        if (a == (8'd1 << i)) begin
          segs[7*i +: 7] = s;
          seen[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rdya !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", rdya); end
    n_cmp++; if (ofa !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", ofa); end
    n_cmp++; if (sa !== 7'h7F) begin n_bad++; $display("FAIL rst_seg got=%h exp=7f", sa); end
    n_cmp++; if (ana !== 4'hF) begin n_bad++; $display("FAIL rst_an got=%b exp=1111", ana); end
    n_cmp++; if (sc !== 7'h00) begin n_bad++; $display("FAIL rst_seg_hi got=%h exp=00", sc); end
    n_cmp++; if (anc !== 3'b000) begin n_bad++; $display("FAIL rst_an_hi got=%b exp=000", anc); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (sa !== 7'h40) begin n_bad++; $display("FAIL post_rst_seg got=%h exp=40", sa); end
    n_cmp++; if (ana !== 4'b1110) begin n_bad++; $display("FAIL post_rst_an got=%b exp=1110", ana); end
    n_cmp++; if (sc !== 7'h3F) begin n_bad++; $display("FAIL post_rst_seg_hi got=%h exp=3f", sc); end
    n_cmp++; if (anc !== 3'b001) begin n_bad++; $display("FAIL post_rst_an_hi got=%b exp=001", anc); end
  endtask

  task automatic test_dec_basic();
    int lows, guard;
    logic [3:0] prev, exp_an;
    logic [6:0] exp_s;
    load(0, 1234, 1'b0, 1'b0, lows);
    n_cmp++; if (lows !== 15) begin n_bad++; $display("FAIL dec_lat got=%0d exp=15", lows); end
    n_cmp++; if (ofa !== 1'b0) begin n_bad++; $display("FAIL dec_ovf got=%b exp=0", ofa); end
    prev = ana;
    guard = 0;
    while (!(ana == 4'b1110 && prev != 4'b1110) && guard < 50) begin
      prev = ana;
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (guard >= 50) begin n_bad++; $display("FAIL dec_sync got=%0d exp=<50", guard); end
    for (int s = 0; s < 4; s++) begin
      exp_an = ~(4'd1 << s);
      exp_s  = model_seg(1234, 1'b0, 1'b0, 4, s);
      n_cmp++; if (ana !== exp_an) begin n_bad++; $display("FAIL dec_an slot=%0d got=%b exp=%b", s, ana, exp_an); end
      n_cmp++; if (sa !== exp_s) begin n_bad++; $display("FAIL dec_seg slot=%0d got=%h exp=%h", s, sa, exp_s); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ana !== exp_an) begin n_bad++; $display("FAIL dec_hold slot=%0d got=%b exp=%b", s, ana, exp_an); end
      @(posedge clk); #1;
    end
    n_cmp++; if (ana !== 4'b1110) begin n_bad++; $display("FAIL dec_wrap got=%b exp=1110", ana); end
  endtask

  task automatic test_overflow();
    int lows;
    logic [55:0] segs;
    logic [7:0] seen;
    int unsigned vals [2] = '{10000, 9999};
    foreach (vals[j]) begin
      load(0, vals[j], 1'b0, 1'b0, lows);
      n_cmp++; if (ofa !== model_ovf(vals[j], 1'b0, 4)) begin n_bad++; $display("FAIL ovf_flag v=%0d got=%b", vals[j], ofa); end
      capture(0, segs, seen);
      n_cmp++; if (seen !== 8'h0F) begin n_bad++; $display("FAIL ovf_seen got=%h exp=0f", seen); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (segs[7*k +: 7] !== model_seg(vals[j], 1'b0, 1'b0, 4, k)) begin
          n_bad++; $display("FAIL ovf_seg v=%0d dig=%0d got=%h exp=%h", vals[j], k, segs[7*k +: 7], model_seg(vals[j], 1'b0, 1'b0, 4, k));
        end
      end
    end
  endtask

  task automatic test_hex();
    int lows;
    logic [55:0] segs;
    logic [7:0] seen;
    logic [6:0] beef [4] = '{7'h0E, 7'h06, 7'h06, 7'h03};
    load(1, 16'hBEEF, 1'b1, 1'b0, lows);
    n_cmp++; if (lows !== 1) begin n_bad++; $display("FAIL hex_lat got=%0d exp=1", lows); end
    n_cmp++; if (ofb !== 1'b0) begin n_bad++; $display("FAIL hex_ovf got=%b exp=0", ofb); end
    capture(1, segs, seen);
    n_cmp++; if (seen !== 8'h0F) begin n_bad++; $display("FAIL hex_seen got=%h exp=0f", seen); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (segs[7*k +: 7] !== beef[k]) begin n_bad++; $display("FAIL hex_seg dig=%0d got=%h exp=%h", k, segs[7*k +: 7], beef[k]); end
    end
  endtask

  task automatic test_blank();
    int lows;
    logic [55:0] segs;
    logic [7:0] seen;
    int unsigned vals [3] = '{7, 0, 7};
    bit blzs [3] = '{1'b1, 1'b1, 1'b0};
    foreach (vals[j]) begin
      load(0, vals[j], 1'b0, blzs[j], lows);
      capture(0, segs, seen);
      n_cmp++; if (seen !== 8'h0F) begin n_bad++; $display("FAIL blz_seen got=%h exp=0f", seen); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (segs[7*k +: 7] !== model_seg(vals[j], 1'b0, blzs[j], 4, k)) begin
          n_bad++; $display("FAIL blz_seg v=%0d blz=%0d dig=%0d got=%h exp=%h", vals[j], blzs[j], k, segs[7*k +: 7], model_seg(vals[j], 1'b0, blzs[j], 4, k));
        end
      end
    end
  endtask

  task automatic test_random_a();
    int lows;
    logic [55:0] segs;
    logic [7:0] seen;
    bit blz;
    int unsigned vals [$] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};
    repeat (8) vals.push_back($urandom_range(0, 16383));
    foreach (vals[j]) begin
      blz = 1'($urandom_range(0, 1));
      load(0, vals[j], 1'b0, blz, lows);
      n_cmp++; if (lows !== 15) begin n_bad++; $display("FAIL ra_lat v=%0d got=%0d exp=15", vals[j], lows); end
      n_cmp++; if (ofa !== model_ovf(vals[j], 1'b0, 4)) begin n_bad++; $display("FAIL ra_ovf v=%0d got=%b", vals[j], ofa); end
      capture(0, segs, seen);
      n_cmp++; if (seen !== 8'h0F) begin n_bad++; $display("FAIL ra_seen got=%h exp=0f", seen); end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (segs[7*k +: 7] !== model_seg(vals[j], 1'b0, blz, 4, k)) begin
          n_bad++; $display("FAIL ra_seg v=%0d blz=%0d dig=%0d got=%h exp=%h", vals[j], blz, k, segs[7*k +: 7], model_seg(vals[j], 1'b0, blz, 4, k));
        end
      end
    end
  endtask

  task automatic test_random_b();
    int lows, exp_lows;
    logic [55:0] segs;
    logic [7:0] seen;
    bit blz, hx;
    int unsigned v;
    for (int j = 0; j < 10; j++) begin
      v   = $urandom_range(0, 65535);
      hx  = (j % 2 == 0);
      blz = 1'($urandom_range(0, 1));
      exp_lows = hx ? 1 : 17;
      load(1, v, hx, blz, lows);
      n_cmp++; if (lows !== exp_lows) begin n_bad++; $display("FAIL rb_lat v=%0d got=%0d exp=%0d", v, lows, exp_lows); end
      n_cmp++; if (ofb !== model_ovf(v, hx, 4)) begin n_bad++; $display("FAIL rb_ovf v=%0d got=%b", v, ofb); end
      capture(1, segs, seen);
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (segs[7*k +: 7] !== model_seg(v, hx, blz, 4, k)) begin
          n_bad++; $display("FAIL rb_seg v=%0d hx=%0d dig=%0d got=%h exp=%h", v, hx, k, segs[7*k +: 7], model_seg(v, hx, blz, 4, k));
        end
      end
    end
  endtask

  task automatic test_random_c();
    int lows, exp_lows;
    logic [55:0] segs;
    logic [7:0] seen;
    bit blz, hx;
    int unsigned vals [$] = '{999, 1000, 1023};
    repeat (7) vals.push_back($urandom_range(0, 1023));
    foreach (vals[j]) begin
      hx  = (j >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      blz = 1'($urandom_range(0, 1));
      exp_lows = hx ? 1 : 11;
      load(2, vals[j], hx, blz, lows);
      n_cmp++; if (lows !== exp_lows) begin n_bad++; $display("FAIL rc_lat v=%0d got=%0d exp=%0d", vals[j], lows, exp_lows); end
      n_cmp++; if (ofc !== model_ovf(vals[j], hx, 3)) begin n_bad++; $display("FAIL rc_ovf v=%0d got=%b", vals[j], ofc); end
      capture(2, segs, seen);
      n_cmp++; if (seen !== 8'h07) begin n_bad++; $display("FAIL rc_seen got=%h exp=07", seen); end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (segs[7*k +: 7] !== model_seg(vals[j], hx, blz, 3, k)) begin
          n_bad++; $display("FAIL rc_seg v=%0d hx=%0d dig=%0d got=%h exp=%h", vals[j], hx, k, segs[7*k +: 7], model_seg(vals[j], hx, blz, 3, k));
        end
      end
    end
  endtask

  task automatic test_refresh_c();
    int lows, guard;
    logic [2:0] prev, exp_an;
    logic [6:0] exp_s;
    load(2, 305, 1'b0, 1'b0, lows);
    prev = anc;
    guard = 0;
    while (!(anc == 3'b001 && prev != 3'b001) && guard < 40) begin
      prev = anc;
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++; if (guard >= 40) begin n_bad++; $display("FAIL ref_sync got=%0d exp=<40", guard); end
    for (int s = 0; s < 4; s++) begin
      exp_an = 3'b001 << (s % 3);
      exp_s  = ~model_seg(305, 1'b0, 1'b0, 3, s % 3);
      n_cmp++; if (anc !== exp_an) begin n_bad++; $display("FAIL ref_an slot=%0d got=%b exp=%b", s, anc, exp_an); end
      n_cmp++; if (sc !== exp_s) begin n_bad++; $display("FAIL ref_seg slot=%0d got=%h exp=%h", s, sc, exp_s); end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (anc !== exp_an) begin n_bad++; $display("FAIL ref_hold slot=%0d got=%b exp=%b", s, anc, exp_an); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drop_and_abort();
    int guard;
    logic [55:0] segs;
    logic [7:0] seen;
    va = 1'b1; da = 14'd1234; hxa = 1'b0; bza = 1'b0;
    @(posedge clk); #1;
    va = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    va = 1'b1; da = 14'd42;
    @(posedge clk); #1;
    va = 1'b0;
    n_cmp++; if (rdya !== 1'b0) begin n_bad++; $display("FAIL drop_busy got=%b exp=0", rdya); end
    guard = 0;
    while (rdya !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (guard >= 100) begin n_bad++; $display("FAIL drop_timeout got=%0d exp=<100", guard); end
    capture(0, segs, seen);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (segs[7*k +: 7] !== model_seg(1234, 1'b0, 1'b0, 4, k)) begin
        n_bad++; $display("FAIL drop_seg dig=%0d got=%h exp=%h", k, segs[7*k +: 7], model_seg(1234, 1'b0, 1'b0, 4, k));
      end
    end
    va = 1'b1; da = 14'd5678;
    @(posedge clk); #1;
    va = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (rdya !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", rdya); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (rdya !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b exp=1", rdya); end
    n_cmp++; if (sa !== 7'h7F) begin n_bad++; $display("FAIL abort_seg got=%h exp=7f", sa); end
    n_cmp++; if (ana !== 4'hF) begin n_bad++; $display("FAIL abort_an got=%b exp=1111", ana); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (rdya !== 1'b1) begin n_bad++; $display("FAIL abort_idle got=%b exp=1", rdya); end
    n_cmp++; if (ofa !== 1'b0) begin n_bad++; $display("FAIL abort_ovf got=%b exp=0", ofa); end
    capture(0, segs, seen);
    n_cmp++; if (seen !== 8'h0F) begin n_bad++; $display("FAIL abort_seen got=%h exp=0f", seen); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (segs[7*k +: 7] !== 7'h40) begin n_bad++; $display("FAIL abort_seg dig=%0d got=%h exp=40", k, segs[7*k +: 7]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    va = 1'b0; hxa = 1'b0; bza = 1'b0; da = '0;
    vb = 1'b0; hxb = 1'b0; bzb = 1'b0; db = '0;
    vc = 1'b0; hxc = 1'b0; bzc = 1'b0; dc = '0;
    #1;
    test_reset();
    test_dec_basic();
    test_overflow();
    test_hex();
    test_blank();
    test_random_a();
    test_random_b();
    test_random_c();
    test_refresh_c();
    test_drop_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
